// File: rtl/readout_serializer.sv
// Parallel-to-serial readout engine: takes a WIDTH-bit word over a valid/ready
// handshake, shifts it out MSB first, then pulses load_out for the downstream register.
module readout_serializer #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             shift_out,
  output logic             shift_en,
  output logic             frame_start,
  output logic             load_out,
  output logic             busy
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_data_ready;
  logic             r_shift_en;
  logic             r_frame_start;
  logic             r_load_out;
  logic             r_busy;

  logic             w_accept;

  // Ready is a registered flag, so the handshake never reaches an output combinationally.
  assign w_accept = r_data_ready & data_valid;

  // NOTE: every register here is updated with <= so all of them see the pre-edge values;
  // reset is asynchronous, so outputs reach their reset values without a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_sreg        <= '0;
      r_cnt         <= '0;
      r_data_ready  <= 1'b1;
      r_shift_en    <= 1'b0;
      r_frame_start <= 1'b0;
      r_load_out    <= 1'b0;
      r_busy        <= 1'b0;
    end else if (w_accept) begin
      r_state       <= SHIFT;
      r_sreg        <= data_in;
      r_cnt         <= '0;
      r_data_ready  <= 1'b0;
      r_shift_en    <= 1'b1;
      r_frame_start <= 1'b1;
      r_load_out    <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      case (r_state)
        SHIFT: begin
          r_sreg        <= {r_sreg[WIDTH-2:0], 1'b0};
          r_cnt         <= r_cnt + CW'(1);
          r_frame_start <= 1'b0;
          if (r_cnt == LAST) begin
            r_state      <= LOAD;
            r_shift_en   <= 1'b0;
            r_load_out   <= 1'b1;
            r_data_ready <= 1'b1;
          end
        end
        default: begin
          // LOAD with no new word, or IDLE: settle in IDLE.
          r_state       <= IDLE;
          r_data_ready  <= 1'b1;
          r_shift_en    <= 1'b0;
          r_frame_start <= 1'b0;
          r_load_out    <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign shift_out   = r_shift_en & r_sreg[WIDTH-1];
  assign shift_en    = r_shift_en;
  assign frame_start = r_frame_start;
  assign load_out    = r_load_out;
  assign busy        = r_busy;
  assign data_ready  = r_data_ready;

endmodule
